// File: rtl/timer_pkg.sv
// Shared constants and FSM encoding for the microwave timer-entry path.
// Entry register layout is {m_tens, m_units, s_tens, s_units}, one BCD nibble each.
package timer_pkg;

  localparam logic [2:0] NUM_DIGITS   = 3'd4;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  localparam int S_UNITS_LSB = 0;
  localparam int S_TENS_LSB  = 4;
  localparam int M_TENS_LSB  = 12;
  localparam int TIME_W      = M_TENS_LSB + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    RELEASE = 2'd2,
    LOCKED  = 2'd3
  } entry_state_t;

  function automatic logic [3:0] sec_tens(input logic [TIME_W-1:0] t);
    return t[S_TENS_LSB +: 4];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Stable-level counter and code latch for the keypad encoder outputs.
// Phase comes from the owning FSM; press/released/abort are same-cycle strobes.
module key_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE = 4  // must be >= 2: the IDLE cycle counts as the first stable one
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  entry_state_t state,
  input  logic         key_dv,
  input  logic [3:0]   key_code,
  output logic         press,
  output logic         released,
  output logic         abort,
  output logic [3:0]   code
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(DEBOUNCE - 1));

  always_comb begin
    press    = 1'b0;
    released = 1'b0;
    abort    = 1'b0;
    case (state)
      ACCEPT: begin
        if (key_dv && (key_code == code)) press = last;
        else                              abort = 1'b1;
      end
      RELEASE: released = !key_dv && last;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      code <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= key_dv ? CW'(1) : '0;
          if (key_dv) code <= key_code;
        end
        ACCEPT:  cnt <= (press || abort) ? '0 : cnt + CW'(1);
        // Any bounce back to high restarts the release window.
        RELEASE: cnt <= (key_dv || released) ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced digit entry into an MM:SS BCD register,
// start validation with a one-cycle load to the countdown timer, and keypad lock.
module keypad_entry_ctrl
  import timer_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_code,
  input  logic              key_dv,
  input  logic              start,
  input  logic              clear,
  input  logic              busy,
  output logic              enc_en,
  output logic [TIME_W-1:0] time_bcd,
  output logic [2:0]        digit_cnt,
  output logic              load,
  output logic              err,
  output logic              locked,
  output entry_state_t      dbg_state
);

  entry_state_t state;
  logic         seen_busy;
  logic         press;
  logic         released;
  logic         abort;
  logic [3:0]   press_code;
  logic         entry_ok;

  assign dbg_state = state;
  assign entry_ok  = (digit_cnt != 3'd0) && (sec_tens(time_bcd) <= SEC_TENS_MAX);

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .state    (state),
    .key_dv   (key_dv),
    .key_code (key_code),
    .press    (press),
    .released (released),
    .abort    (abort),
    .code     (press_code)
  );

  always_ff @(posedge clk) begin
    load <= 1'b0;
    err  <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      time_bcd  <= '0;
      digit_cnt <= '0;
      locked    <= 1'b0;
      enc_en    <= 1'b0;
      seen_busy <= 1'b0;
    end else if (clear) begin
      // Clearing does not stop a running timer; it only releases the keypad.
      state     <= IDLE;
      time_bcd  <= '0;
      digit_cnt <= '0;
      locked    <= 1'b0;
      enc_en    <= 1'b1;
      seen_busy <= 1'b0;
    end else begin
      enc_en <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            if (!entry_ok) begin
              err <= 1'b1;
            end else begin
              load      <= 1'b1;
              state     <= LOCKED;
              locked    <= 1'b1;
              enc_en    <= 1'b0;
              seen_busy <= 1'b0;
            end
          end else if (key_dv) begin
            state <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (press) begin
            state <= RELEASE;
            if ((press_code <= BCD_MAX) && (digit_cnt < NUM_DIGITS)) begin
              time_bcd  <= {time_bcd[M_TENS_LSB-1:S_UNITS_LSB], press_code};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (abort) begin
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (released) state <= IDLE;
        end
        LOCKED: begin
          enc_en <= 1'b0;
          if (busy) seen_busy <= 1'b1;
          // Exit only on the falling edge of busy, so a slow timer start is tolerated.
          if (seen_busy && !busy) begin
            state     <= IDLE;
            time_bcd  <= '0;
            digit_cnt <= '0;
            locked    <= 1'b0;
            enc_en    <= 1'b1;
            seen_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences the microwave timer-input path: enables the 10-key encoder, debounces its `dv`/`B` outputs, and accepts one digit per key press.
- Digits shift into a 4-digit BCD MM:SS entry register.
- On `start`, validates the entry and hands it to the countdown timer with a one-cycle load pulse.
- Locks the keypad while the timer runs.
- Sits between the encoder and the countdown timer.

Parameters:
- DEBOUNCE, 4, consecutive stable cycles required for both key-accept and key-release.
- NUM_DIGITS, 4, digits in the entry register (MM:SS). Fixed at 4; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_code  in  4  BCD code from encoder `B`
- key_dv  in  1  encoder data-valid `dv`
- start  in  1  start request, level, sampled each cycle
- clear  in  1  clear request, level
- busy  in  1  countdown timer running
- enc_en  out  1  encoder enable, high = encoder active
- time_bcd  out  16  entry register {m_tens, m_units, s_tens, s_units}
- digit_cnt  out  3  digits entered, 0..4
- load  out  1  one-cycle pulse; `time_bcd` is valid in the same cycle
- err  out  1  one-cycle pulse on rejected start
- locked  out  1  high while the timer owns the time value

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE; `time_bcd`=0, `digit_cnt`=0, `load`=0, `err`=0, `locked`=0, `enc_en`=0. `enc_en`=1 from the first cycle after `rst` deasserts.
- All outputs are registered.
- States:
  - IDLE: no key held.
  - ACCEPT: counting a stable press.
  - RELEASE: waiting for a stable release.
  - LOCKED: timer running.
- IDLE → ACCEPT: `key_dv`=1. Latch `key_code`; debounce counter=1.
- In ACCEPT:
  - Each cycle with `key_dv`=1 and `key_code` equal to the latched code, increment the counter.
  - `key_dv`=0 or a changed code → IDLE, counter=0.
  - Counter reaches DEBOUNCE → accept the digit and go to RELEASE.
- Digit accept:
  - Codes >9 are discarded.
  - If `digit_cnt`=4, the digit is discarded and the register is unchanged.
  - Otherwise `time_bcd` <= {`time_bcd`[11:0], code} and `digit_cnt`++.
  - The update is visible the cycle after the DEBOUNCE-th stable cycle.
- In RELEASE:
  - Counter counts consecutive `key_dv`=0 cycles; any `key_dv`=1 resets it.
  - Counter reaches DEBOUNCE → IDLE.
  - Holding a key yields exactly one digit.
- Start, accepted only in IDLE with `start`=1 and `busy`=0:
  - If `digit_cnt`=0 or s_tens>5: pulse `err` one cycle and stay in IDLE; the register is unchanged.
  - Otherwise: pulse `load` one cycle, then LOCKED. `locked`=1 and `enc_en`=0 from the next cycle.
  - `start` in ACCEPT or RELEASE is ignored.
- In LOCKED:
  - Keys are ignored.
  - An internal seen_busy flag sets when `busy`=1.
  - Exit to IDLE on the first cycle with seen_busy=1 and `busy`=0. On exit: `time_bcd`=0, `digit_cnt`=0, `locked`=0, `enc_en`=1.
- Clear: highest priority, in any state including LOCKED.
  - Next cycle: IDLE, `time_bcd`=0, `digit_cnt`=0, counters 0, `locked`=0, `enc_en`=1.
  - No `load` or `err` is issued that cycle.
  - Clearing in LOCKED does not stop the timer; the timer owner handles that.
- Priority on the same cycle: `rst` > `clear` > `start` > key events.
- Reset mid-press: the next press starts a fresh debounce. No partial digit is retained.
- `start` held high:
  - Re-evaluated each IDLE cycle.
  - A rejected start held high pulses `err` every IDLE cycle.
  - After a successful load, LOCKED blocks re-triggering.

Decomposition:
- Shared package `timer_pkg`:
  - NUM_DIGITS=4.
  - BCD_MAX=9, SEC_TENS_MAX=5.
  - State encoding: IDLE, ACCEPT, RELEASE, LOCKED, 2 bits.
  - Digit-nibble index constants.
- One sub-module: `key_debounce`, holding the stable-level counter and code latch. It outputs a one-cycle `press` strobe with the code, and a `released` strobe.
- The top-level FSM handles entry, start/validation and lock.

Test Plan (bench with DEBOUNCE=4):
- Press keys 1,2,3,0, each `key_dv` held 6 cycles then low 6 cycles; assert `start` → `time_bcd`=16'h1230, `digit_cnt`=4, `load`=1 for exactly one cycle; then `locked`=1 and `enc_en`=0.
- Toggle `key_dv` as 3 cycles high, 1 low, 3 high with code 5 (bounce) → no digit accepted; then hold 4 cycles → exactly one digit, `time_bcd`=16'h0005.
- Enter 0,1,7,5 then `start` → s_tens=7>5, `err` pulses once, `load`=0, stays IDLE with `time_bcd` unchanged. Fifth key 9 after 4 digits → ignored.
- After `load`: drive `busy`=1 for 10 cycles then 0; keys pressed meanwhile ignored → return to IDLE with `time_bcd`=0 and `enc_en`=1 the cycle after `busy` falls.
- Assert `clear` and `start` in the same cycle with 2 digits entered → no `load`, `time_bcd`=0, `digit_cnt`=0.
- Assert `rst` mid-ACCEPT (2 stable cycles) → all outputs at reset values; the next full press is accepted normally.
